// File: rtl/ps2_lane_input_if.sv
// Bundle of the scancode byte stream, raw pushbuttons and lane-request
// outputs exchanged between the input front-end and its surroundings.
interface ps2_lane_input_if;
    logic [7:0] ps2_byte;
    logic       ps2_byte_valid;
    logic       key_left_n;
    logic       key_right_n;
    logic       move_left;
    logic       move_right;
    logic [3:0] held_keys;

    // Source side: drives bytes and buttons, observes the lane requests.
    modport master (
        output ps2_byte,
        output ps2_byte_valid,
        output key_left_n,
        output key_right_n,
        input  move_left,
        input  move_right,
        input  held_keys
    );

    // Front-end side: consumes bytes and buttons, produces lane requests.
    modport slave (
        input  ps2_byte,
        input  ps2_byte_valid,
        input  key_left_n,
        input  key_right_n,
        output move_left,
        output move_right,
        output held_keys
    );
endinterface

// File: rtl/ps2_lane_input.sv
// PS/2 set-2 scancode decoder plus debounced pushbuttons, merged into
// mutually exclusive move_left / move_right level requests for the
// player lane-control block.
module ps2_lane_input #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DEBOUNCE_BITS   = 19,
    parameter int PREFIX_TIMEOUT  = 1000000,
    parameter int TIMEOUT_BITS    = 20
) (
    input  logic            Clock,
    input  logic            Resetn,
    ps2_lane_input_if.slave lane
);

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;

    // Flag positions inside r_flags, matching the held_keys debug layout.
    localparam int F_LARROW = 0;
    localparam int F_RARROW = 1;
    localparam int F_A      = 2;
    localparam int F_D      = 3;

    localparam logic [DEBOUNCE_BITS-1:0] DB_LAST = DEBOUNCE_BITS'(DEBOUNCE_CYCLES - 1);
    localparam logic [TIMEOUT_BITS-1:0]  TO_LAST = TIMEOUT_BITS'(PREFIX_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_E0   = 2'd1,
        GOT_F0   = 2'd2,
        GOT_E0F0 = 2'd3
    } state_t;

    // Scancode decoder state
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_flags;
    logic [3:0]              w_flags_nxt;
    logic [TIMEOUT_BITS-1:0] r_to_cnt;
    logic [TIMEOUT_BITS-1:0] w_to_cnt_nxt;

    // Pushbutton path; index 0 = left, 1 = right
    logic [1:0]               r_sync1;
    logic [1:0]               r_sync2;
    logic [1:0]               w_btn_pressed;
    logic [1:0]               r_btn_db;
    logic [DEBOUNCE_BITS-1:0] r_db_cnt [2];

    // Output stage
    logic       w_req_left;
    logic       w_req_right;
    logic       r_move_left;
    logic       r_move_right;
    logic [3:0] r_held_keys;

    // Decoder state register: state, held-key flags and prefix timeout counter.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state  <= IDLE;
            r_flags  <= '0;
            r_to_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_flags  <= w_flags_nxt;
            r_to_cnt <= w_to_cnt_nxt;
        end
    end

    // Decoder next state: consume one byte per strobe, otherwise age any pending prefix.
    always_comb begin
        w_state_nxt  = r_state;
        w_flags_nxt  = r_flags;
        w_to_cnt_nxt = r_to_cnt;

        if (lane.ps2_byte_valid) begin
            w_to_cnt_nxt = '0;
            case (r_state)
                IDLE: begin
                    case (lane.ps2_byte)
                        SC_EXT:  w_state_nxt = GOT_E0;
                        SC_BRK:  w_state_nxt = GOT_F0;
                        SC_A:    w_flags_nxt[F_A] = 1'b1;
                        SC_D:    w_flags_nxt[F_D] = 1'b1;
                        default: w_state_nxt = IDLE;
                    endcase
                end
                GOT_E0: begin
                    case (lane.ps2_byte)
                        SC_BRK:  w_state_nxt = GOT_E0F0;
                        SC_EXT:  w_state_nxt = GOT_E0;
                        SC_LEFT: begin
                            w_flags_nxt[F_LARROW] = 1'b1;
                            w_state_nxt           = IDLE;
                        end
                        SC_RIGHT: begin
                            w_flags_nxt[F_RARROW] = 1'b1;
                            w_state_nxt           = IDLE;
                        end
                        default: w_state_nxt = IDLE;
                    endcase
                end
                GOT_F0: begin
                    case (lane.ps2_byte)
                        SC_A: begin
                            w_flags_nxt[F_A] = 1'b0;
                            w_state_nxt      = IDLE;
                        end
                        SC_D: begin
                            w_flags_nxt[F_D] = 1'b0;
                            w_state_nxt      = IDLE;
                        end
                        SC_EXT:  w_state_nxt = GOT_E0;
                        SC_BRK:  w_state_nxt = GOT_F0;
                        default: w_state_nxt = IDLE;
                    endcase
                end
                GOT_E0F0: begin
                    case (lane.ps2_byte)
                        SC_LEFT: begin
                            w_flags_nxt[F_LARROW] = 1'b0;
                            w_state_nxt           = IDLE;
                        end
                        SC_RIGHT: begin
                            w_flags_nxt[F_RARROW] = 1'b0;
                            w_state_nxt           = IDLE;
                        end
                        SC_EXT:  w_state_nxt = GOT_E0;
                        default: w_state_nxt = IDLE;
                    endcase
                end
                default: w_state_nxt = IDLE;
            endcase
        end else if (r_state != IDLE) begin
            // A prefix with no follow-up byte is stale; drop it so a lost
            // byte cannot reinterpret the next keystroke.
            if (r_to_cnt == TO_LAST) begin
                w_state_nxt  = IDLE;
                w_to_cnt_nxt = '0;
            end else begin
                w_to_cnt_nxt = r_to_cnt + 1'b1;
            end
        end else begin
            w_to_cnt_nxt = '0;
        end
    end

    // Two-flop synchronizer for the asynchronous pushbuttons; resets to released (high).
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
        end else begin
            r_sync1 <= {lane.key_right_n, lane.key_left_n};
            r_sync2 <= r_sync1;
        end
    end

    assign w_btn_pressed = ~r_sync2;

    // Debounce: the pressed state only follows a level that stays different for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge Clock) begin
        for (int i = 0; i < 2; i++) begin
            if (!Resetn) begin
                r_btn_db[i] <= 1'b0;
                r_db_cnt[i] <= '0;
            end else if (w_btn_pressed[i] == r_btn_db[i]) begin
                r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DB_LAST) begin
                r_btn_db[i] <= w_btn_pressed[i];
                r_db_cnt[i] <= '0;
            end else begin
                r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
            end
        end
    end

    assign w_req_left  = r_flags[F_LARROW] | r_flags[F_A] | r_btn_db[0];
    assign w_req_right = r_flags[F_RARROW] | r_flags[F_D] | r_btn_db[1];

    // Output register: opposing requests cancel so the player never sees both directions.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_move_left  <= 1'b0;
            r_move_right <= 1'b0;
            r_held_keys  <= '0;
        end else begin
            r_move_left  <= w_req_left & ~w_req_right;
            r_move_right <= w_req_right & ~w_req_left;
            r_held_keys  <= r_flags;
        end
    end

    assign lane.move_left  = r_move_left;
    assign lane.move_right = r_move_right;
    assign lane.held_keys  = r_held_keys;

endmodule

// File: tb/tb_ps2_lane_input.sv
// Bench for ps2_lane_input: directed scenarios followed by random bytes and
// button activity, checked by a scoreboard of expected output transitions.
module tb_ps2_lane_input;

    localparam int DB = 4;
    localparam int PT = 8;

    logic Clock;
    logic Resetn;

    ps2_lane_input_if bus ();

    ps2_lane_input #(
        .DEBOUNCE_CYCLES(DB),
        .DEBOUNCE_BITS  (19),
        .PREFIX_TIMEOUT (PT),
        .TIMEOUT_BITS   (20)
    ) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .lane  (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        int         cyc;
        logic [5:0] val;
    } exp_t;

    exp_t       expq[$];
    int         total = 0;
    int         bad   = 0;
    int         edge_n = 0;
    bit         mon_on = 0;
    logic [5:0] last_seen = '0;
    bit         kl_lvl = 1'b1;
    bit         kr_lvl = 1'b1;

    // Reference model state
    bit         m_la, m_ra, m_a, m_d;
    bit         m_ext, m_brk;
    int         m_last_byte;
    bit         m_db[2];
    bit         m_p1[2];
    bit         m_p2[2];
    int         m_since[2];
    bit         hs[2][8192];
    logic [5:0] m_last = '0;

    task automatic model_step(input bit rn, input bit v, input logic [7:0] b,
                              input bit kl, input bit kr);
        bit         l, r, s, flip;
        bit         pr[2];
        logic [5:0] o;
        exp_t       e;
        pr[0] = ~kl;
        pr[1] = ~kr;
        if (!rn) begin
            m_la = 0; m_ra = 0; m_a = 0; m_d = 0;
            m_ext = 0; m_brk = 0;
            for (int i = 0; i < 2; i++) begin
                m_db[i] = 0; m_p1[i] = 0; m_p2[i] = 0; m_since[i] = 0;
            end
            o = '0;
        end else begin
            // outputs after this edge reflect the state left by the previous edge
            l = m_la | m_a | m_db[0];
            r = m_ra | m_d | m_db[1];
            o = {l & ~r, r & ~l, m_d, m_a, m_ra, m_la};
            // buttons: level seen two edges late; pressed state flips after DB equal differing samples
            for (int i = 0; i < 2; i++) begin
                s = m_p2[i];
                m_p2[i] = m_p1[i];
                m_p1[i] = pr[i];
                hs[i][edge_n % 8192] = s;
                m_since[i]++;
                if (m_since[i] >= DB) begin
                    flip = 1;
                    for (int j = 0; j < DB; j++)
                        if (hs[i][(edge_n - j) % 8192] == m_db[i]) flip = 0;
                    if (flip) m_db[i] = ~m_db[i];
                end
            end
            // scancodes: pending prefix expires after PT idle cycles
            if (v) begin
                if ((m_ext | m_brk) && (edge_n - m_last_byte - 1 >= PT)) begin
                    m_ext = 0; m_brk = 0;
                end
                m_last_byte = edge_n;
                if (b == 8'hE0) begin
                    m_ext = 1; m_brk = 0;
                end else if (b == 8'hF0) begin
                    if (m_ext && m_brk) begin
                        m_ext = 0; m_brk = 0;
                    end else begin
                        m_brk = 1;
                    end
                end else begin
                    if (m_ext) begin
                        if (b == 8'h6B) m_la = ~m_brk;
                        else if (b == 8'h74) m_ra = ~m_brk;
                    end else begin
                        if (b == 8'h1C) m_a = ~m_brk;
                        else if (b == 8'h23) m_d = ~m_brk;
                    end
                    m_ext = 0; m_brk = 0;
                end
            end
        end
        if (o != m_last) begin
            e.cyc = edge_n;
            e.val = o;
            expq.push_back(e);
        end
        m_last = o;
    endtask

    task automatic tick(input bit rn, input bit v, input logic [7:0] b);
        Resetn             = rn;
        bus.ps2_byte_valid = v;
        bus.ps2_byte       = b;
        bus.key_left_n     = kl_lvl;
        bus.key_right_n    = kr_lvl;
        @(posedge Clock);
        edge_n++;
        model_step(rn, v, b, kl_lvl, kr_lvl);
        @(negedge Clock);
    endtask

    task automatic send(input logic [7:0] b);
        tick(1'b1, 1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 8'h00);
    endtask

    task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%b want=%b (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    function automatic logic [5:0] outs();
        return {bus.move_left, bus.move_right, bus.held_keys};
    endfunction

    logic [7:0] tbl[10];

    initial begin
        tbl[0] = 8'hE0; tbl[1] = 8'hF0; tbl[2] = 8'h6B; tbl[3] = 8'h74; tbl[4] = 8'h1C;
        tbl[5] = 8'h23; tbl[6] = 8'hE0; tbl[7] = 8'hF0; tbl[8] = 8'h12; tbl[9] = 8'h5A;

        Resetn             = 1'b0;
        bus.ps2_byte       = 8'h00;
        bus.ps2_byte_valid = 1'b0;
        bus.key_left_n     = 1'b1;
        bus.key_right_n    = 1'b1;

        // Monitor: every change of the outputs must match the next expected transition.
        fork
            begin : monitor
                logic [5:0] cur;
                exp_t       e;
                forever begin
                    @(negedge Clock);
                    if (mon_on) begin
                        cur = outs();
                        if (cur !== last_seen) begin
                            total++;
                            if (expq.size() == 0) begin
                                bad++;
                                $display("FAIL unexpected_change edge=%0d got=%b want=%b",
                                         edge_n, cur, last_seen);
                            end else begin
                                e = expq.pop_front();
                                if (e.cyc != edge_n || e.val !== cur) begin
                                    bad++;
                                    $display("FAIL out_change edge=%0d got=%b want=%b at edge %0d",
                                             edge_n, cur, e.val, e.cyc);
                                end
                            end
                            last_seen = cur;
                        end
                    end
                end
            end
        join_none

        tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
        chk("reset_outputs", outs(), 6'b00_0000);
        last_seen = '0;
        mon_on    = 1;

        // 1: left arrow make, then break
        send(8'hE0); send(8'h6B); idle(1);
        chk("t1_left_make", outs(), 6'b10_0001);
        send(8'hE0); send(8'hF0); send(8'h6B); idle(1);
        chk("t1_left_break", outs(), 6'b00_0000);
        idle(2);

        // 2: A then D (conflict), then release A
        send(8'h1C); idle(1);
        chk("t2_a_make", outs(), 6'b10_0100);
        send(8'h23); idle(1);
        chk("t2_conflict", outs(), 6'b00_1100);
        send(8'hF0); send(8'h1C); idle(1);
        chk("t2_a_break", outs(), 6'b01_1000);
        send(8'hF0); send(8'h23); idle(2);

        // 3: stale E0 prefix expires, 6B alone is ignored
        send(8'hE0); idle(8); send(8'h6B); idle(2);
        chk("t3_timeout", outs(), 6'b00_0000);

        // 4: short glitch rejected, long press asserts on the 7th edge from the first low sample
        kl_lvl = 0; idle(3); kl_lvl = 1; idle(8);
        chk("t4_glitch", outs(), 6'b00_0000);
        kl_lvl = 0; idle(6);
        chk("t4_press_early", outs(), 6'b00_0000);
        idle(1);
        chk("t4_press", outs(), 6'b10_0000);
        idle(3);
        kl_lvl = 1; idle(6);
        chk("t4_release_early", outs(), 6'b10_0000);
        idle(1);
        chk("t4_release", outs(), 6'b00_0000);
        idle(2);

        // 5: reset with a pending break prefix
        send(8'hE0); send(8'h74); idle(1);
        chk("t5_right_make", outs(), 6'b01_0010);
        send(8'hE0); send(8'hF0);
        tick(1'b0, 1'b0, 8'h00);
        chk("t5_reset", outs(), 6'b00_0000);
        send(8'h74); idle(2);
        chk("t5_after_reset", outs(), 6'b00_0000);

        // 6: typematic repeats keep move_right steady
        for (int i = 0; i < 5; i++) begin
            send(8'hE0); send(8'h74);
        end
        idle(1);
        chk("t6_typematic", outs(), 6'b01_0010);
        send(8'hE0); send(8'hF0); send(8'h74); idle(1);
        chk("t6_break", outs(), 6'b00_0000);
        idle(2);

        // Random phase
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(9, 0) == 0) kl_lvl = ~kl_lvl;
            if ($urandom_range(9, 0) == 0) kr_lvl = ~kr_lvl;
            if ($urandom_range(399, 0) == 0) begin
                tick(1'b0, 1'b0, 8'h00);
            end else if ($urandom_range(39, 0) == 0) begin
                idle(int'($urandom_range(10, 6)));
            end else if ($urandom_range(2, 0) == 0) begin
                send(tbl[$urandom_range(9, 0)]);
            end else begin
                tick(1'b1, 1'b0, 8'h00);
            end
        end

        kl_lvl = 1; kr_lvl = 1;
        idle(16);

        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL pending_transitions: got=%0d left want=0", expq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
